// File: rtl/noc_pkg.sv
// Shared router types: port and FSM encodings, packet length, XY routing function.
// Pure definitions, no latency; no handshake of its own.
package noc_pkg;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int         PKT_FLITS = 5;
    localparam logic [2:0] NO_GRANT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        REQ,
        SEND
    } state_e;

    // Dimension-ordered routing: resolve X completely before Y.
    function automatic port_e xy_route(input logic [7:0] dx, input logic [7:0] dy,
                                       input logic [7:0] myx, input logic [7:0] myy);
        if (dx > myx)      return PORT_E;
        else if (dx < myx) return PORT_W;
        else if (dy > myy) return PORT_S;
        else if (dy < myy) return PORT_N;
        else               return PORT_L;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with full/empty/count, async active-low reset.
// Head visible combinationally on pop_dat; push takes effect next cycle.
// Push ignored when full, pop ignored when empty; full depends on count only.
module noc_flit_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [FLIT_W-1:0] push_dat,
    input  logic              pop_vld,
    output logic [FLIT_W-1:0] pop_dat,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_vld & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, XY-routes the head, requests an output arbiter, streams 5 flits.
// Head at FIFO head -> req_o 2 cycles later; grant in cycle G -> first out_valid_o in G+1.
// in_ready_o low when FIFO full; out_ready_i low stalls the beat. NOC_IP_STATS_EN adds pkt_cnt_o/stall_o.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int DEPTH   = 8,
    parameter int PORT_ID = 0,
    parameter int COORD_W = 2,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_W-1:0]     in_flit_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [4:0]            req_o,
    input  logic [4:0][2:0]       grant_idx_i,
    output logic [FLIT_W-1:0]     out_flit_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2:0]            out_port_o
`ifdef NOC_IP_STATS_EN
    ,
    output logic [15:0]           pkt_cnt_o,
    output logic                  stall_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_e            state;
    logic [2:0]        beat_cnt;
    logic [FLIT_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              beat;
    logic [7:0]        dx;
    logic [7:0]        dy;
    port_e             route;
    logic [2:0]        grant_sel;

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid_i),
        .push_dat (in_flit_i),
        .pop_vld  (beat),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign in_ready_o  = ~fifo_full;
    assign out_flit_o  = head;
    assign out_valid_o = (state == SEND) & ~fifo_empty;
    assign beat        = out_valid_o & out_ready_i;

    always_comb begin
        dx = '0;
        dy = '0;
        dx[COORD_W-1:0] = head[COORD_W-1:0];
        dy[COORD_W-1:0] = head[2*COORD_W-1:COORD_W];
        route = xy_route(dx, dy, 8'(MY_X), 8'(MY_Y));
    end

    // Only the arbiter we are requesting matters; others' grants are ignored.
    always_comb begin
        grant_sel = NO_GRANT;
        for (int p = 0; p < 5; p++) begin
            if (out_port_o == 3'(p)) grant_sel = grant_idx_i[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            req_o      <= '0;
            out_port_o <= NO_GRANT;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) state <= ROUTE;
                end
                ROUTE: begin
                    out_port_o <= route;
                    req_o      <= 5'(1) << route;
                    state      <= REQ;
                end
                REQ: begin
                    if (grant_sel == 3'(PORT_ID)) begin
                        state    <= SEND;
                        beat_cnt <= '0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (beat_cnt == 3'(PKT_FLITS - 1)) begin
                            state      <= IDLE;
                            beat_cnt   <= '0;
                            req_o      <= '0;
                            out_port_o <= NO_GRANT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NOC_IP_STATS_EN
    logic pkt_done;

    assign pkt_done = (state == SEND) & beat & (beat_cnt == 3'(PKT_FLITS - 1));
    assign stall_o  = (state == REQ) | ((state == SEND) & fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_o <= '0;
        end else if (pkt_done && pkt_cnt_o != 16'hFFFF) begin
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port at router (1,1), input E (PORT_ID=2), with a flit scoreboard.
module tb_noc_input_port;
    import noc_pkg::*;

    localparam int FLIT_W  = 32;
    localparam int DEPTH   = 8;
    localparam int PORT_ID = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        req;
    logic [4:0][2:0]   grant;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_port;
`ifdef NOC_IP_STATS_EN
    logic [15:0]       pkt_cnt;
    logic              stall;
`endif

    int                vectors     = 0;
    int                miscompares = 0;
    int                beats       = 0;
    int                b0;
    logic [FLIT_W-1:0] sb [$];
    logic [FLIT_W-1:0] mon_exp;

    always #5 clk = ~clk;

    noc_input_port #(
        .FLIT_W  (FLIT_W),
        .DEPTH   (DEPTH),
        .PORT_ID (PORT_ID),
        .COORD_W (2),
        .MY_X    (1),
        .MY_Y    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit_i   (in_flit),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .req_o       (req),
        .grant_idx_i (grant),
        .out_flit_o  (out_flit),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_port_o  (out_port)
`ifdef NOC_IP_STATS_EN
        ,
        .pkt_cnt_o   (pkt_cnt),
        .stall_o     (stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beats are sampled on the falling edge, half a cycle before the edge that commits them.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_beat: observed %0h expected no flit", out_flit);
            end else begin
                mon_exp = sb.pop_front();
                assert (out_flit === mon_exp) else begin
                    miscompares++;
                    $error("FAIL beat_flit: observed %0h expected %0h", out_flit, mon_exp);
                end
            end
        end
    end

    function automatic logic [31:0] head_flit(input int dx, input int dy, input int tag);
        return {16'hCAFE, 8'(tag), 4'h0, 2'(dy), 2'(dx)};
    endfunction

    function automatic logic [31:0] pay_flit(input int tag, input int i);
        return {16'hBEEF, 8'(tag), 8'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] f);
        in_flit  = f;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !in_ready; n++) tick();
        check("push_accept", 32'(in_ready), 32'd1);
        sb.push_back(f);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int dx, input int dy, input int tag);
        push(head_flit(dx, dy, tag));
        for (int i = 1; i < 5; i++) push(pay_flit(tag, i));
    endtask

    task automatic wait_req();
        for (int n = 0; n < 50 && req == 5'b0; n++) tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    int          rt_dx   [3] = '{1, 1, 0};
    int          rt_dy   [3] = '{1, 0, 3};
    logic [4:0]  rt_req  [3] = '{5'b10000, 5'b00001, 5'b01000};
    int          rt_port [3] = '{4, 0, 3};

    initial begin
        rst_n     = 1'b0;
        in_flit   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int p = 0; p < 5; p++) grant[p] = NO_GRANT;
        tick();
        tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_port", 32'(out_port), 32'd7);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_req", 32'(req), 32'd0);

        // Packet east: request, grant latency, five ordered beats, release.
        b0 = beats;
        send_pkt(3, 1, 1);
        wait_req();
        check("t1_req", 32'(req), 32'b00100);
        check("t1_port", 32'(out_port), 32'd2);
        tick();
        tick();
        check("t1_no_valid_before_grant", 32'(out_valid), 32'd0);
        grant[2] = 3'd2;
        tick();
        check("t1_valid_after_grant", 32'(out_valid), 32'd1);
        drain();
        check("t1_req_drop", 32'(req), 32'd0);
        check("t1_port_idle", 32'(out_port), 32'd7);
        check("t1_beats", 32'(beats - b0), 32'd5);
        grant[2] = NO_GRANT;

        // Other routing directions.
        for (int k = 0; k < 3; k++) begin
            send_pkt(rt_dx[k], rt_dy[k], 2 + k);
            wait_req();
            check("t2_req", 32'(req), 32'(rt_req[k]));
            check("t2_port", 32'(out_port), 32'(rt_port[k]));
            grant[rt_port[k]] = 3'd2;
            drain();
            check("t2_req_drop", 32'(req), 32'd0);
            grant[rt_port[k]] = NO_GRANT;
        end

        // Grants to no one or to another input must be ignored.
        send_pkt(3, 1, 5);
        wait_req();
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t3_none_valid", 32'(out_valid), 32'd0);
        end
        grant[2] = 3'd3;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("t3_other_valid", 32'(out_valid), 32'd0);
        end
        check("t3_req_held", 32'(req), 32'b00100);
`ifdef NOC_IP_STATS_EN
        check("t3_stall", 32'(stall), 32'd1);
`endif
        grant[2] = 3'd2;
        drain();
        check("t3_req_drop", 32'(req), 32'd0);
        grant[2] = NO_GRANT;

        // Fill the FIFO with the output blocked; ninth flit waits for a pop.
        out_ready = 1'b0;
        send_pkt(3, 1, 6);
        push(head_flit(3, 1, 7));
        push(pay_flit(7, 1));
        push(pay_flit(7, 2));
        check("t4_full", 32'(in_ready), 32'd0);
        in_flit  = pay_flit(7, 3);
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t4_held_off", 32'(in_ready), 32'd0);
        end
        grant[2]  = 3'd2;
        out_ready = 1'b1;
        push(pay_flit(7, 3));
        push(pay_flit(7, 4));
        drain();
        check("t4_req_drop", 32'(req), 32'd0);

        // Starved mid-packet: valid drops, request holds, counter resumes.
        b0 = beats;
        push(head_flit(3, 1, 8));
        push(pay_flit(8, 1));
        drain();
        for (int n = 0; n < 6; n++) begin
            tick();
            check("t5_gap_valid", 32'(out_valid), 32'd0);
        end
        check("t5_gap_req", 32'(req), 32'b00100);
`ifdef NOC_IP_STATS_EN
        check("t5_gap_stall", 32'(stall), 32'd1);
`endif
        for (int i = 2; i < 5; i++) push(pay_flit(8, i));
        drain();
        check("t5_req_drop", 32'(req), 32'd0);
        check("t5_beats", 32'(beats - b0), 32'd5);

        // Asynchronous reset after the third beat.
        b0 = beats;
        send_pkt(3, 1, 9);
        for (int n = 0; n < 100 && (beats - b0) < 3; n++) tick();
        check("t6_three_beats", 32'(beats - b0), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(req), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_port", 32'(out_port), 32'd7);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_req", 32'(req), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
`ifdef NOC_IP_STATS_EN
        check("t6_pkt_cnt_rst", 32'(pkt_cnt), 32'd0);
`endif
        send_pkt(3, 1, 10);
        drain();
        check("t6_req_drop", 32'(req), 32'd0);
`ifdef NOC_IP_STATS_EN
        check("t6_pkt_cnt_one", 32'(pkt_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
